// File: rtl/dbn_pkg.sv
// Shared types, width helpers and default sizing for the DBN layer engine.
package dbn_pkg;

    // Default configuration of one layer engine
    localparam int unsigned DEF_ELEM_W     = 16;
    localparam int unsigned DEF_ELEMS      = 16;
    localparam int unsigned DEF_NEURONS    = 16;
    localparam int unsigned DEF_ACC_W      = 32;
    localparam int unsigned DEF_MAX_CHUNKS = 64;

    // Ceiling log2; clog2(1) == 0
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Exact width of a sum of `elems` signed elem_w x elem_w products
    function automatic int unsigned dot_width(input int unsigned elem_w, input int unsigned elems);
        return 2 * elem_w + clog2(elems);
    endfunction

    // Width that holds acc + dot without wrapping, so clamping is exact
    function automatic int unsigned sum_width(input int unsigned acc_w, input int unsigned dot_w);
        return ((dot_w > acc_w) ? dot_w : acc_w) + 1;
    endfunction

    // Saturation limits of a signed accumulator of width acc_w (acc_w <= 64)
    function automatic logic [63:0] acc_max(input int unsigned acc_w);
        return (64'd1 << (acc_w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] acc_min(input int unsigned acc_w);
        return ~acc_max(acc_w);
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dbn_dot_unit.sv
// Combinational signed dot product of one neuron's weight chunk with the data chunk.
module dbn_dot_unit
    import dbn_pkg::*;
#(
    parameter int unsigned ELEM_W = DEF_ELEM_W,
    parameter int unsigned ELEMS  = DEF_ELEMS,
    localparam int unsigned DOT_W = dot_width(ELEM_W, ELEMS)
) (
    input  logic [ELEMS*ELEM_W-1:0]  data_in,
    input  logic [ELEMS*ELEM_W-1:0]  weight_in,
    output logic signed [DOT_W-1:0]  dot_c
);

    // Sum of full-precision products, sign-extended to the exact dot width
    always_comb begin
        logic signed [ELEM_W-1:0]   a;
        logic signed [ELEM_W-1:0]   b;
        logic signed [2*ELEM_W-1:0] p;
        a     = '0;
        b     = '0;
        p     = '0;
        dot_c = '0;
        for (int k = 0; k < int'(ELEMS); k++) begin
            a     = data_in[k*ELEM_W +: ELEM_W];
            b     = weight_in[k*ELEM_W +: ELEM_W];
            p     = a * b;
            dot_c = dot_c + DOT_W'(p);
        end
    end

endmodule

// File: rtl/dbn_layer_engine.sv
// Streaming fully-connected DBN layer: per-neuron dot products accumulated over
// a run-time number of chunks, with bias preload, saturation and optional ReLU.
module dbn_layer_engine
    import dbn_pkg::*;
#(
    parameter int unsigned ELEM_W     = DEF_ELEM_W,
    parameter int unsigned ELEMS      = DEF_ELEMS,
    parameter int unsigned NEURONS    = DEF_NEURONS,
    parameter int unsigned ACC_W      = DEF_ACC_W,
    parameter int unsigned MAX_CHUNKS = DEF_MAX_CHUNKS,
    localparam int unsigned CNT_W     = clog2(MAX_CHUNKS + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  num_chunks,
    input  logic                              relu_en,
    input  logic [NEURONS*ACC_W-1:0]          bias_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ELEMS*ELEM_W-1:0]           data_in,
    input  logic [NEURONS*ELEMS*ELEM_W-1:0]   weight_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NEURONS*ACC_W-1:0]          sum_out,
    output logic                              busy,
    output logic                              sat_flag
);

    localparam int unsigned DOT_W = dot_width(ELEM_W, ELEMS);
    localparam int unsigned SUM_W = sum_width(ACC_W, DOT_W);
    localparam int unsigned TOP_W = SUM_W - ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(acc_min(ACC_W));
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);

    state_t state_q;
    state_t state_d;

    logic                     load_c;
    logic                     xfer_c;
    logic                     last_c;
    logic [CNT_W-1:0]         nch_c;
    logic [CNT_W-1:0]         nch_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     relu_q;
    logic                     s1_valid_q;
    logic                     sat_any_c;

    logic signed [DOT_W-1:0]  dot_c   [NEURONS];
    logic signed [DOT_W-1:0]  dot_q   [NEURONS];
    logic signed [ACC_W-1:0]  acc_q   [NEURONS];
    logic signed [ACC_W-1:0]  acc_d_c [NEURONS];
    logic [NEURONS*ACC_W-1:0] result_c;

    // One dot-product unit per neuron, each on its own weight row-chunk
    for (genvar n = 0; n < int'(NEURONS); n++) begin : g_dot
        dbn_dot_unit #(
            .ELEM_W (ELEM_W),
            .ELEMS  (ELEMS)
        ) u_dot (
            .data_in   (data_in),
            .weight_in (weight_in[n*ELEMS*ELEM_W +: ELEMS*ELEM_W]),
            .dot_c     (dot_c[n])
        );
    end

    // Next-state and transfer decode
    always_comb begin
        state_d = state_q;
        load_c  = 1'b0;
        xfer_c  = in_valid && in_ready && (state_q == ST_ACCUM);
        last_c  = xfer_c && (CNT_W'(cnt_q + 1'b1) == nch_q);
        nch_c   = (num_chunks > CNT_MAX) ? CNT_MAX : num_chunks;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = (nch_c == '0) ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_c) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake/status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            nch_q     <= '0;
            cnt_q     <= '0;
            relu_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == ST_ACCUM);
            out_valid <= (state_d == ST_DONE);
            busy      <= (state_d != ST_IDLE);
            if (load_c) begin
                nch_q  <= nch_c;
                relu_q <= relu_en;
                cnt_q  <= '0;
            end else if (xfer_c) begin
                cnt_q  <= CNT_W'(cnt_q + 1'b1);
            end
        end
    end

    // Stage-2 saturating add and output shaping (ReLU) for every neuron
    always_comb begin
        logic signed [SUM_W-1:0] sum;
        logic [TOP_W-1:0]        top;
        logic signed [ACC_W-1:0] eff;
        sum       = '0;
        top       = '0;
        eff       = '0;
        sat_any_c = 1'b0;
        result_c  = '0;
        for (int n = 0; n < int'(NEURONS); n++) begin
            sum = SUM_W'(acc_q[n]) + SUM_W'(dot_q[n]);
            top = sum[SUM_W-1:ACC_W-1];
            if ((top == '0) || (top == '1)) begin
                acc_d_c[n] = sum[ACC_W-1:0];
            end else begin
                acc_d_c[n] = sum[SUM_W-1] ? ACC_MIN : ACC_MAX;
                if (s1_valid_q) sat_any_c = 1'b1;
            end
            eff = s1_valid_q ? acc_d_c[n] : acc_q[n];
            result_c[n*ACC_W +: ACC_W] = (relu_q && eff[ACC_W-1]) ? '0 : eff;
        end
    end

    // Stage-1 dot register, accumulators, sticky saturation and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            sat_flag   <= 1'b0;
            sum_out    <= '0;
            for (int n = 0; n < int'(NEURONS); n++) begin
                dot_q[n] <= '0;
                acc_q[n] <= '0;
            end
        end else begin
            s1_valid_q <= xfer_c;
            for (int n = 0; n < int'(NEURONS); n++) begin
                if (xfer_c) dot_q[n] <= dot_c[n];
                if (load_c) begin
                    acc_q[n] <= bias_in[n*ACC_W +: ACC_W];
                end else if (s1_valid_q) begin
                    acc_q[n] <= acc_d_c[n];
                end
            end
            if (load_c) begin
                sat_flag <= 1'b0;
            end else if (sat_any_c) begin
                sat_flag <= 1'b1;
            end
            if (state_q == ST_FLUSH) sum_out <= result_c;
        end
    end

endmodule
